multicycle_ctrl_fsm: RTL and testbench

//  Parametrised multi-cycle successor to the single-cycle decode control unit.

---
 rtl/multicycle_ctrl_fsm.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes.
// Every memory access is guarded by a wait counter; a missing ack halts with bus_err.
module multicycle_ctrl_fsm #(
    parameter int INSTR_W     = 32,
    parameter int OPC_W       = 6,
    parameter int ALUOP_W     = 3,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [INSTR_W-1:0] instr,
    input  logic               alu_zero,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic [2:0]         state_o,
    output logic               illegal,
    output logic               bus_err,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    localparam logic [OPC_W-1:0] OP_R    = OPC_W'(4'd0);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(4'd1);
    localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(4'd2);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(4'd3);
    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(4'd4);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(4'd5);
    localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(4'd6);
    localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(4'd7);
    localparam logic [OPC_W-1:0] OP_SLTI = OPC_W'(4'd8);
    localparam logic [OPC_W-1:0] OP_J    = OPC_W'(4'd9);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'b100);
    localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'b111);

    state_t             state_r, next_state_s;
    logic [OPC_W-1:0]   opc_r;
    logic [WCNT_W-1:0]  wcnt_r;
    logic               illegal_r, bus_err_r;
    logic [CNT_W-1:0]   retired_r;
    logic [OPC_W-1:0]   opc_in_s;
    logic               in_mem_s, timeout_s, retire_s, illegal_set_s, bus_err_set_s;

    assign opc_in_s  = instr[INSTR_W-1 -: OPC_W];
    assign in_mem_s  = (state_r == S_FETCH) || (state_r == S_MEM);
    assign timeout_s = in_mem_s && !mem_ack && (wcnt_r == WAIT_LAST);
    assign state_o   = state_r;
    assign illegal   = illegal_r;
    assign bus_err   = bus_err_r;
    assign retired   = retired_r;

    // Next-state decode and per-state datapath strobes.
    always_comb begin
        next_state_s  = state_r;
        retire_s      = 1'b0;
        illegal_set_s = 1'b0;
        bus_err_set_s = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_iord      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'd0;
        alu_src_b     = 1'b0;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        case (state_r)
            S_IDLE: begin
                next_state_s = run ? S_FETCH : S_IDLE;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    next_state_s = S_DECODE;
                end else if (timeout_s) begin
                    bus_err_set_s = 1'b1;
                    next_state_s  = S_HALT;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (instr == {INSTR_W{1'b0}}) begin
                    retire_s = 1'b1;
                end else if (opc_in_s > OP_J) begin
                    illegal_set_s = 1'b1;
                    next_state_s  = S_HALT;
                end else begin
                    next_state_s = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opc_r)
                    OP_R: begin
                        alu_op       = ALU_FUNCT;
                        next_state_s = S_WB;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_op   = ALU_SUB;
                        pc_src   = 2'd1;
                        pc_write = (opc_r == OP_BEQ) ? alu_zero : !alu_zero;
                        retire_s = 1'b1;
                    end
                    OP_J: begin
                        pc_src   = 2'd2;
                        pc_write = 1'b1;
                        retire_s = 1'b1;
                    end
                    OP_SW, OP_LW: begin
                        alu_src_b    = 1'b1;
                        next_state_s = S_MEM;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                        alu_src_b    = 1'b1;
                        alu_op       = (opc_r == OP_ANDI) ? ALU_AND :
                                       (opc_r == OP_ORI)  ? ALU_OR  :
                                       (opc_r == OP_SLTI) ? ALU_SLT : ALU_ADD;
                        next_state_s = S_WB;
                    end
                    default: begin
                        // Unreachable: DECODE filters opcodes above j.
                        illegal_set_s = 1'b1;
                        next_state_s  = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_iord  = 1'b1;
                mem_we    = (opc_r == OP_SW);
                alu_src_b = 1'b1;
                if (mem_ack) begin
                    retire_s     = (opc_r == OP_SW);
                    next_state_s = S_WB;
                end else if (timeout_s) begin
                    bus_err_set_s = 1'b1;
                    next_state_s  = S_HALT;
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opc_r == OP_R);
                mem_to_reg = (opc_r == OP_LW);
                retire_s   = 1'b1;
            end
            S_HALT: begin
                next_state_s = S_HALT;
            end
            default: begin
                next_state_s = S_HALT;
            end
        endcase
        // A retiring instruction overrides whatever successor was chosen above.
        next_state_s = retire_s ? (run ? S_FETCH : S_IDLE) : next_state_s;
    end

    // State, latched opcode, wait counter, sticky flags and retired counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            opc_r     <= {OPC_W{1'b0}};
            wcnt_r    <= {WCNT_W{1'b0}};
            illegal_r <= 1'b0;
            bus_err_r <= 1'b0;
            retired_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (state_r == S_DECODE) begin
                opc_r <= opc_in_s;
            end
            if (in_mem_s && !mem_ack && !timeout_s) begin
                wcnt_r <= wcnt_r + WCNT_W'(1'b1);
            end else begin
                wcnt_r <= {WCNT_W{1'b0}};
            end
            if (illegal_set_s) begin
                illegal_r <= 1'b1;
            end
            if (bus_err_set_s) begin
                bus_err_r <= 1'b1;
            end
            if (retire_s) begin
                retired_r <= retired_r + CNT_W'(1'b1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench: stimulus pushes the hand-derived expected output of each cycle,
// a negedge monitor pops and compares it against the DUT.
module tb_multicycle_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst, run, alu_zero, mem_ack;
    logic [31:0] instr;
    logic        mem_req, mem_we, mem_iord, ir_write, pc_write, alu_src_b;
    logic        reg_write, reg_dst, mem_to_reg, illegal, bus_err;
    logic [1:0]  pc_src, retired;
    logic [2:0]  alu_op, state_o;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .INSTR_W(32), .OPC_W(6), .ALUOP_W(3), .CNT_W(2), .MEM_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .instr(instr), .alu_zero(alu_zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_iord(mem_iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state_o(state_o),
        .illegal(illegal), .bus_err(bus_err), .retired(retired)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [13:0] sb;
        logic [1:0]  fl;
        logic [1:0]  ret;
    } exp_t;

    // Strobe order: req we iord irw pcw pcsrc[1:0] srcb aluop[2:0] rw rdst m2r
    localparam logic [13:0] Z    = 14'b0_0_0_0_0_00_0_000_0_0_0;
    localparam logic [13:0] FW   = 14'b1_0_0_0_0_00_0_000_0_0_0;
    localparam logic [13:0] FA   = 14'b1_0_0_1_1_00_0_000_0_0_0;
    localparam logic [13:0] XR   = 14'b0_0_0_0_0_00_0_010_0_0_0;
    localparam logic [13:0] XBT  = 14'b0_0_0_0_1_01_0_001_0_0_0;
    localparam logic [13:0] XBN  = 14'b0_0_0_0_0_01_0_001_0_0_0;
    localparam logic [13:0] XJ   = 14'b0_0_0_0_1_10_0_000_0_0_0;
    localparam logic [13:0] XMA  = 14'b0_0_0_0_0_00_1_000_0_0_0;
    localparam logic [13:0] XAND = 14'b0_0_0_0_0_00_1_011_0_0_0;
    localparam logic [13:0] MLW  = 14'b1_0_1_0_0_00_1_000_0_0_0;
    localparam logic [13:0] MSW  = 14'b1_1_1_0_0_00_1_000_0_0_0;
    localparam logic [13:0] WR   = 14'b0_0_0_0_0_00_0_000_1_1_0;
    localparam logic [13:0] WLW  = 14'b0_0_0_0_0_00_0_000_1_0_1;
    localparam logic [13:0] WI   = 14'b0_0_0_0_0_00_0_000_1_0_0;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    function automatic logic [31:0] mk(input logic [5:0] op);
        return {op, 26'h0ABCDE};
    endfunction

    // Drive one cycle of inputs and queue what the outputs must look like mid-cycle.
    task automatic cyc(input string tag, input logic r, input logic ack, input logic az,
                       input logic [2:0] st, input logic [13:0] sb,
                       input logic [1:0] fl, input logic [1:0] ret);
        exp_t e;
        rst      = r;
        mem_ack  = ack;
        alu_zero = az;
        e.st = st; e.sb = sb; e.fl = fl; e.ret = ret;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT outputs against the queued expectation each negedge.
    always @(negedge clk) begin
        exp_t  e, a;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a.st  = state_o;
            a.sb  = {mem_req, mem_we, mem_iord, ir_write, pc_write, pc_src, alu_src_b,
                     alu_op, reg_write, reg_dst, mem_to_reg};
            a.fl  = {illegal, bus_err};
            a.ret = retired;
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got st=%0d sb=%b ill/berr=%b ret=%0d, want st=%0d sb=%b ill/berr=%b ret=%0d",
                         t, a.st, a.sb, a.fl, a.ret, e.st, e.sb, e.fl, e.ret);
            end
        end
    end

    initial begin
        rst = 1'b1; run = 1'b0; instr = 32'd0; mem_ack = 1'b0; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc("rst0", 1'b1, 1'b0, 1'b0, 3'd0, Z, 2'b00, 2'd0);
        // R-type, zero-wait
        run = 1'b1; instr = mk(6'd0);
        cyc("t1_idle",  1'b0, 1'b0, 1'b0, 3'd0, Z,  2'b00, 2'd0);
        cyc("t1_fetch", 1'b0, 1'b1, 1'b0, 3'd1, FA, 2'b00, 2'd0);
        cyc("t1_dec",   1'b0, 1'b0, 1'b0, 3'd2, Z,  2'b00, 2'd0);
        cyc("t1_exec",  1'b0, 1'b0, 1'b0, 3'd3, XR, 2'b00, 2'd0);
        cyc("t1_wb",    1'b0, 1'b0, 1'b0, 3'd5, WR, 2'b00, 2'd0);
        // lw with ack on third MEM cycle
        instr = mk(6'd4);
        cyc("t2_fetch", 1'b0, 1'b1, 1'b0, 3'd1, FA,  2'b00, 2'd1);
        cyc("t2_dec",   1'b0, 1'b0, 1'b0, 3'd2, Z,   2'b00, 2'd1);
        cyc("t2_exec",  1'b0, 1'b0, 1'b0, 3'd3, XMA, 2'b00, 2'd1);
        cyc("t2_mem0",  1'b0, 1'b0, 1'b0, 3'd4, MLW, 2'b00, 2'd1);
        cyc("t2_mem1",  1'b0, 1'b0, 1'b0, 3'd4, MLW, 2'b00, 2'd1);
        cyc("t2_mem2",  1'b0, 1'b1, 1'b0, 3'd4, MLW, 2'b00, 2'd1);
        cyc("t2_wb",    1'b0, 1'b0, 1'b0, 3'd5, WLW, 2'b00, 2'd1);
        // bne not taken, then taken
        instr = mk(6'd2);
        cyc("t3_f_nt",  1'b0, 1'b1, 1'b0, 3'd1, FA,  2'b00, 2'd2);
        cyc("t3_d_nt",  1'b0, 1'b0, 1'b0, 3'd2, Z,   2'b00, 2'd2);
        cyc("t3_bne_nt",1'b0, 1'b0, 1'b1, 3'd3, XBN, 2'b00, 2'd2);
        cyc("t3_f_t",   1'b0, 1'b1, 1'b0, 3'd1, FA,  2'b00, 2'd3);
        cyc("t3_d_t",   1'b0, 1'b0, 1'b0, 3'd2, Z,   2'b00, 2'd3);
        cyc("t3_bne_t", 1'b0, 1'b0, 1'b0, 3'd3, XBT, 2'b00, 2'd3);
        // j, counter has wrapped after four retires
        instr = mk(6'd9);
        cyc("t6_wrap",  1'b0, 1'b1, 1'b0, 3'd1, FA, 2'b00, 2'd0);
        cyc("j_dec",    1'b0, 1'b0, 1'b0, 3'd2, Z,  2'b00, 2'd0);
        cyc("j_exec",   1'b0, 1'b0, 1'b0, 3'd3, XJ, 2'b00, 2'd0);
        // beq taken
        instr = mk(6'd1);
        cyc("beq_f",    1'b0, 1'b1, 1'b0, 3'd1, FA,  2'b00, 2'd1);
        cyc("beq_d",    1'b0, 1'b0, 1'b0, 3'd2, Z,   2'b00, 2'd1);
        cyc("beq_x",    1'b0, 1'b0, 1'b1, 3'd3, XBT, 2'b00, 2'd1);
        // NOP, then NOP retiring with run low
        instr = 32'd0;
        cyc("t5_nop_f", 1'b0, 1'b1, 1'b0, 3'd1, FA, 2'b00, 2'd2);
        cyc("t5_nop_d", 1'b0, 1'b0, 1'b0, 3'd2, Z,  2'b00, 2'd2);
        cyc("nop2_f",   1'b0, 1'b1, 1'b0, 3'd1, FA, 2'b00, 2'd3);
        run = 1'b0;
        cyc("nop2_d",   1'b0, 1'b0, 1'b0, 3'd2, Z,  2'b00, 2'd3);
        cyc("nop_idle", 1'b0, 1'b0, 1'b0, 3'd0, Z,  2'b00, 2'd0);
        run = 1'b1; instr = mk(6'd6);
        cyc("andi_idle",1'b0, 1'b0, 1'b0, 3'd0, Z,    2'b00, 2'd0);
        cyc("andi_f",   1'b0, 1'b1, 1'b0, 3'd1, FA,   2'b00, 2'd0);
        cyc("andi_d",   1'b0, 1'b0, 1'b0, 3'd2, Z,    2'b00, 2'd0);
        cyc("andi_x",   1'b0, 1'b0, 1'b0, 3'd3, XAND, 2'b00, 2'd0);
        cyc("andi_wb",  1'b0, 1'b0, 1'b0, 3'd5, WI,   2'b00, 2'd0);
        // sw zero-wait
        instr = mk(6'd3);
        cyc("sw_f",     1'b0, 1'b1, 1'b0, 3'd1, FA,  2'b00, 2'd1);
        cyc("sw_d",     1'b0, 1'b0, 1'b0, 3'd2, Z,   2'b00, 2'd1);
        cyc("sw_x",     1'b0, 1'b0, 1'b0, 3'd3, XMA, 2'b00, 2'd1);
        cyc("sw_mem",   1'b0, 1'b1, 1'b0, 3'd4, MSW, 2'b00, 2'd1);
        // fetch ack on the last allowed cycle; stray acks in DECODE/EXEC ignored
        instr = mk(6'd0);
        cyc("t4_fw0",   1'b0, 1'b0, 1'b0, 3'd1, FW, 2'b00, 2'd2);
        cyc("t4_fw1",   1'b0, 1'b0, 1'b0, 3'd1, FW, 2'b00, 2'd2);
        cyc("t4_fw2",   1'b0, 1'b0, 1'b0, 3'd1, FW, 2'b00, 2'd2);
        cyc("t4_lastack",1'b0,1'b1, 1'b0, 3'd1, FA, 2'b00, 2'd2);
        cyc("t4_dec",   1'b0, 1'b1, 1'b0, 3'd2, Z,  2'b00, 2'd2);
        cyc("t4_exec",  1'b0, 1'b1, 1'b0, 3'd3, XR, 2'b00, 2'd2);
        cyc("t4_wb",    1'b0, 1'b0, 1'b0, 3'd5, WR, 2'b00, 2'd2);
        // fetch timeout
        cyc("t4_to0",   1'b0, 1'b0, 1'b0, 3'd1, FW, 2'b00, 2'd3);
        cyc("t4_to1",   1'b0, 1'b0, 1'b0, 3'd1, FW, 2'b00, 2'd3);
        cyc("t4_to2",   1'b0, 1'b0, 1'b0, 3'd1, FW, 2'b00, 2'd3);
        cyc("t4_to3",   1'b0, 1'b0, 1'b0, 3'd1, FW, 2'b00, 2'd3);
        cyc("t4_halt",  1'b0, 1'b0, 1'b0, 3'd6, Z,  2'b01, 2'd3);
        cyc("t4_hold",  1'b0, 1'b1, 1'b0, 3'd6, Z,  2'b01, 2'd3);
        // illegal opcode
        cyc("rst1",     1'b1, 1'b0, 1'b0, 3'd0, Z,  2'b00, 2'd0);
        instr = mk(6'd10);
        cyc("t5_idle",  1'b0, 1'b0, 1'b0, 3'd0, Z,  2'b00, 2'd0);
        cyc("t5_ill_f", 1'b0, 1'b1, 1'b0, 3'd1, FA, 2'b00, 2'd0);
        cyc("t5_ill_d", 1'b0, 1'b0, 1'b0, 3'd2, Z,  2'b00, 2'd0);
        cyc("t5_halt",  1'b0, 1'b0, 1'b0, 3'd6, Z,  2'b10, 2'd0);
        cyc("t5_hold",  1'b0, 1'b1, 1'b0, 3'd6, Z,  2'b10, 2'd0);
        // async reset in the middle of a sw memory access
        cyc("rst2",     1'b1, 1'b0, 1'b0, 3'd0, Z,   2'b00, 2'd0);
        instr = mk(6'd3);
        cyc("t6_idle",  1'b0, 1'b0, 1'b0, 3'd0, Z,   2'b00, 2'd0);
        cyc("t6_f",     1'b0, 1'b1, 1'b0, 3'd1, FA,  2'b00, 2'd0);
        cyc("t6_d",     1'b0, 1'b0, 1'b0, 3'd2, Z,   2'b00, 2'd0);
        cyc("t6_x",     1'b0, 1'b0, 1'b0, 3'd3, XMA, 2'b00, 2'd0);
        cyc("t6_mem",   1'b0, 1'b0, 1'b0, 3'd4, MSW, 2'b00, 2'd0);
        cyc("t6_rstmem",1'b1, 1'b0, 1'b0, 3'd0, Z,   2'b00, 2'd0);
        run = 1'b0;
        cyc("t6_after", 1'b0, 1'b1, 1'b0, 3'd0, Z,   2'b00, 2'd0);
        cyc("t6_stay",  1'b0, 1'b0, 1'b0, 3'd0, Z,   2'b00, 2'd0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
